delay_buf_sequencer: RTL



---
 rtl/dsp_pkg.sv | 16 +
 rtl/delay_addr_calc.sv | 29 ++
 rtl/delay_buf_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared types and default constants for the chorus delay-line datapath.
package dsp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_OUT
  } seq_state_t;

  localparam int DSP_BUF_DEPTH = 4410;
  localparam int DSP_AVG_DELAY = 882;
  localparam int DSP_PKT_WIDTH = 16;

endpackage

// File: rtl/delay_addr_calc.sv
// Clamped LFO delay and circular read address behind the write pointer.
module delay_addr_calc
  import dsp_pkg::*;
#(
  parameter int BUF_DEPTH  = DSP_BUF_DEPTH,
  parameter int AVG_DELAY  = DSP_AVG_DELAY,
  parameter int ADDR_WIDTH = 13
) (
  input  logic [ADDR_WIDTH-1:0] wr_ptr,
  input  logic [15:0]           extra_delay,
  output logic [ADDR_WIDTH-1:0] delay,
  output logic [ADDR_WIDTH-1:0] rd_addr
);

  localparam int MAX_EXTRA = BUF_DEPTH - 1 - AVG_DELAY;

  logic [31:0] extra_c;
  logic [31:0] rd_wrap;

  always_comb begin
    // Clamp keeps delay in 1..BUF_DEPTH-1 so the read never hits the slot being written.
    extra_c = ({16'd0, extra_delay} > 32'(MAX_EXTRA)) ? 32'(MAX_EXTRA) : {16'd0, extra_delay};
    delay   = ADDR_WIDTH'(extra_c + 32'(AVG_DELAY));
    rd_wrap = 32'(wr_ptr) + 32'(BUF_DEPTH) - 32'(delay);
    if (wr_ptr >= delay) rd_addr = wr_ptr - delay;
    else                 rd_addr = ADDR_WIDTH'(rd_wrap);
  end

endmodule

// File: rtl/delay_buf_sequencer.sv
// Per-sample sequencer for the chorus delay RAM: write dry, read wet, strobe to mixer.
module delay_buf_sequencer
  import dsp_pkg::*;
#(
  parameter int PKT_WIDTH  = DSP_PKT_WIDTH,
  parameter int BUF_DEPTH  = DSP_BUF_DEPTH,
  parameter int AVG_DELAY  = DSP_AVG_DELAY,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [PKT_WIDTH-1:0]  pkt_i,
  input  logic                  pktChanged_i,
  input  logic [15:0]           extraDelay_i,
  output logic [ADDR_WIDTH-1:0] ramAddr_o,
  output logic                  ramWe_o,
  output logic [PKT_WIDTH-1:0]  ramWData_o,
  input  logic [PKT_WIDTH-1:0]  ramRData_i,
  output logic [PKT_WIDTH-1:0]  pktDelayed_o,
  output logic                  pktDelayedChanged_o,
  output logic                  busy_o,
  output logic                  overrun_o
);

  localparam int FILL_W = $clog2(BUF_DEPTH + 1);

  seq_state_t            state;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_addr, delay;
  logic [ADDR_WIDTH-1:0] calc_delay, calc_rd;
  logic [FILL_W-1:0]     fill_cnt;
  logic                  primed;

  // wr_ptr only moves in READ, so the read address can be resolved at accept time.
  delay_addr_calc #(
    .BUF_DEPTH (BUF_DEPTH),
    .AVG_DELAY (AVG_DELAY),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_calc (
    .wr_ptr     (wr_ptr),
    .extra_delay(extraDelay_i),
    .delay      (calc_delay),
    .rd_addr    (calc_rd)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state               <= S_IDLE;
      wr_ptr              <= '0;
      rd_addr             <= '0;
      delay               <= '0;
      fill_cnt            <= '0;
      primed              <= 1'b0;
      ramAddr_o           <= '0;
      ramWe_o             <= 1'b0;
      ramWData_o          <= '0;
      pktDelayed_o        <= '0;
      pktDelayedChanged_o <= 1'b0;
      busy_o              <= 1'b0;
      overrun_o           <= 1'b0;
    end else begin
      ramWe_o             <= 1'b0;
      pktDelayedChanged_o <= 1'b0;
      unique case (state)
        S_IDLE, S_OUT: begin
          if (pktChanged_i) begin
            state      <= S_WRITE;
            busy_o     <= 1'b1;
            delay      <= calc_delay;
            rd_addr    <= calc_rd;
            ramAddr_o  <= wr_ptr;
            ramWe_o    <= 1'b1;
            ramWData_o <= pkt_i;
          end else begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        end
        S_WRITE: begin
          state     <= S_READ;
          ramAddr_o <= rd_addr;
        end
        S_READ: begin
          state  <= S_WAIT;
          wr_ptr <= (wr_ptr == ADDR_WIDTH'(BUF_DEPTH - 1)) ? '0 : wr_ptr + ADDR_WIDTH'(1);
          if (fill_cnt != FILL_W'(BUF_DEPTH)) fill_cnt <= fill_cnt + FILL_W'(1);
          // Priming decision uses the count before this sample was added.
          primed <= 32'(fill_cnt) >= 32'(delay);
        end
        S_WAIT: begin
          state               <= S_OUT;
          pktDelayed_o        <= primed ? ramRData_i : '0;
          pktDelayedChanged_o <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
      if (pktChanged_i && (state == S_WRITE || state == S_READ || state == S_WAIT))
        overrun_o <= 1'b1;
    end
  end

endmodule
